// File: rtl/haze_pkg.sv
// rtl/haze_pkg.sv - shared widths, pixel type and FSM encoding for the haze-removal pipeline
package haze_pkg;

    localparam int DATA_W = 8;
    localparam int IDX_W  = 20;

    typedef struct packed {
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] g;
        logic [DATA_W-1:0] b;
    } pixel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/atmospheric_light_estimator_if.sv
// rtl/atmospheric_light_estimator_if.sv - pixel input beat and frame result bundle
interface atmospheric_light_estimator_if;
    import haze_pkg::*;

    logic              in_valid;
    logic              in_sof;
    logic              in_eof;
    logic [DATA_W-1:0] in_dark;
    logic [DATA_W-1:0] in_r;
    logic [DATA_W-1:0] in_g;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic [DATA_W-1:0] out_a_r;
    logic [DATA_W-1:0] out_a_g;
    logic [DATA_W-1:0] out_a_b;
    logic [DATA_W-1:0] out_dark_max;
    logic [IDX_W-1:0]  out_idx;
    logic              busy;
    logic              frame_err;

    modport master (
        output in_valid, in_sof, in_eof, in_dark, in_r, in_g, in_b,
        input  out_valid, out_a_r, out_a_g, out_a_b, out_dark_max, out_idx, busy, frame_err
    );

    modport slave (
        input  in_valid, in_sof, in_eof, in_dark, in_r, in_g, in_b,
        output out_valid, out_a_r, out_a_g, out_a_b, out_dark_max, out_idx, busy, frame_err
    );

endinterface

// File: rtl/argmax_reg.sv
// rtl/argmax_reg.sv - compare-and-capture register keeping the largest value, its payload and index
module argmax_reg
    import haze_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              cand_valid,
    input  logic [DATA_W-1:0] cand_value,
    input  pixel_t            cand_payload,
    input  logic [IDX_W-1:0]  cand_idx,
    output logic [DATA_W-1:0] value,
    output pixel_t            payload,
    output logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] value_nxt,
    output pixel_t            payload_nxt,
    output logic [IDX_W-1:0]  idx_nxt
);

    // Strict greater-than keeps the earliest pixel on ties.
    logic take;
    assign take = load | (cand_valid & (cand_value > value));

    always_comb begin
        value_nxt   = value;
        payload_nxt = payload;
        idx_nxt     = idx;
        if (take) begin
            value_nxt   = cand_value;
            payload_nxt = cand_payload;
            idx_nxt     = cand_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value   <= '0;
            payload <= '0;
            idx     <= '0;
        end else begin
            value   <= value_nxt;
            payload <= payload_nxt;
            idx     <= idx_nxt;
        end
    end

endmodule

// File: rtl/atmospheric_light_estimator.sv
// rtl/atmospheric_light_estimator.sv - per-frame brightest dark-channel pixel tracker publishing atmospheric light
module atmospheric_light_estimator
    import haze_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    atmospheric_light_estimator_if.slave   bus
);

    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  cnt, cnt_nxt;
    logic              cnt_full, cnt_full_nxt;
    logic              load, cand_valid, publish, err;
    logic [IDX_W-1:0]  cand_idx;

    pixel_t            cand_px, best_px, best_px_nxt;
    logic [DATA_W-1:0] best_val, best_val_nxt;
    logic [IDX_W-1:0]  best_idx, best_idx_nxt;

    logic              out_valid_q, frame_err_q;
    pixel_t            out_a_q;
    logic [DATA_W-1:0] out_dark_q;
    logic [IDX_W-1:0]  out_idx_q;

    assign cand_px = '{r: bus.in_r, g: bus.in_g, b: bus.in_b};

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cnt_full_nxt = cnt_full;
        load         = 1'b0;
        cand_valid   = 1'b0;
        publish      = 1'b0;
        err          = 1'b0;
        cand_idx     = cnt;
        if (bus.in_valid) begin
            if (bus.in_sof) begin
                // A sof restarts the frame from this beat regardless of state.
                load         = 1'b1;
                cand_idx     = '0;
                cnt_nxt      = IDX_W'(1);
                cnt_full_nxt = 1'b0;
                err          = (state == ACCUM);
                publish      = bus.in_eof;
                state_nxt    = bus.in_eof ? IDLE : ACCUM;
            end else if (state == IDLE) begin
                err = 1'b1;
            end else begin
                cand_valid = 1'b1;
                // Once index IDX_MAX has been handed out, further beats reuse it and flag an error.
                if (cnt == IDX_MAX) begin
                    err          = cnt_full;
                    cnt_full_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + IDX_W'(1);
                end
                if (bus.in_eof) begin
                    publish   = 1'b1;
                    state_nxt = IDLE;
                end
            end
        end
    end

    argmax_reg u_argmax (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .cand_valid   (cand_valid),
        .cand_value   (bus.in_dark),
        .cand_payload (cand_px),
        .cand_idx     (cand_idx),
        .value        (best_val),
        .payload      (best_px),
        .idx          (best_idx),
        .value_nxt    (best_val_nxt),
        .payload_nxt  (best_px_nxt),
        .idx_nxt      (best_idx_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cnt_full    <= 1'b0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_dark_q  <= '0;
            out_idx_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cnt_full    <= cnt_full_nxt;
            out_valid_q <= publish;
            frame_err_q <= frame_err_q | err;
            // Publish the post-compare winner so the eof pixel is included.
            if (publish) begin
                out_a_q    <= best_px_nxt;
                out_dark_q <= best_val_nxt;
                out_idx_q  <= best_idx_nxt;
            end
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_a_r      = out_a_q.r;
    assign bus.out_a_g      = out_a_q.g;
    assign bus.out_a_b      = out_a_q.b;
    assign bus.out_dark_max = out_dark_q;
    assign bus.out_idx      = out_idx_q;
    assign bus.busy         = (state == ACCUM);
    assign bus.frame_err    = frame_err_q;

endmodule

// File: tb/tb_atmospheric_light_estimator.sv
// tb/tb_atmospheric_light_estimator.sv - directed self-checking bench for atmospheric_light_estimator
module tb_atmospheric_light_estimator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    atmospheric_light_estimator_if bus ();

    atmospheric_light_estimator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {out_valid, A.r, A.g, A.b, dark_max, idx}
    function automatic logic [52:0] res();
        return {bus.out_valid, bus.out_a_r, bus.out_a_g, bus.out_a_b, bus.out_dark_max, bus.out_idx};
    endfunction

    task automatic beat(input logic sof, input logic eof, input logic [7:0] d,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_eof   = eof;
        bus.in_dark  = d;
        bus.in_r     = r;
        bus.in_g     = g;
        bus.in_b     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eof   = 1'b0;
    endtask

    task automatic bubble(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;
        bus.in_dark = '0; bus.in_r = '0; bus.in_g = '0; bus.in_b = '0;
        rst_n = 1'b0;
        bubble(2);
        n_checks++;
        if (res() !== 53'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected %h", res(), 53'd0);
        end
        n_checks++;
        if ({bus.busy, bus.frame_err} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00", {bus.busy, bus.frame_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        bubble(1);
    endtask

    task automatic test_basic();
        beat(1, 0, 8'd10, 8'd1, 8'd1, 8'd1);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_busy: got %b expected 1", bus.busy);
        end
        beat(0, 0, 8'd200, 8'd220, 8'd210, 8'd205);
        beat(0, 0, 8'd50, 8'd5, 8'd5, 8'd5);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_early_valid: got %b expected 0", bus.out_valid);
        end
        beat(0, 1, 8'd199, 8'd250, 8'd250, 8'd250);
        n_checks++;
        if (res() !== {1'b1, 8'd220, 8'd210, 8'd205, 8'd200, 20'd1}) begin
            n_fail++; $display("FAIL basic_result: got %h expected %h", res(), {1'b1, 8'd220, 8'd210, 8'd205, 8'd200, 20'd1});
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy_after: got %b expected 0", bus.busy);
        end
        bubble(1);
        n_checks++;
        if (res() !== {1'b0, 8'd220, 8'd210, 8'd205, 8'd200, 20'd1}) begin
            n_fail++; $display("FAIL basic_hold: got %h expected %h", res(), {1'b0, 8'd220, 8'd210, 8'd205, 8'd200, 20'd1});
        end
    endtask

    task automatic test_tie();
        beat(1, 0, 8'd90, 8'd11, 8'd12, 8'd13);
        beat(0, 0, 8'd90, 8'd21, 8'd22, 8'd23);
        beat(0, 1, 8'd90, 8'd31, 8'd32, 8'd33);
        n_checks++;
        if (res() !== {1'b1, 8'd11, 8'd12, 8'd13, 8'd90, 20'd0}) begin
            n_fail++; $display("FAIL tie_result: got %h expected %h", res(), {1'b1, 8'd11, 8'd12, 8'd13, 8'd90, 20'd0});
        end
        bubble(1);
    endtask

    task automatic test_single();
        beat(1, 1, 8'd7, 8'd1, 8'd2, 8'd3);
        n_checks++;
        if (res() !== {1'b1, 8'd1, 8'd2, 8'd3, 8'd7, 20'd0}) begin
            n_fail++; $display("FAIL single_result: got %h expected %h", res(), {1'b1, 8'd1, 8'd2, 8'd3, 8'd7, 20'd0});
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL single_busy: got %b expected 0", bus.busy);
        end
        bubble(1);
    endtask

    task automatic test_back_to_back();
        beat(1, 0, 8'd5, 8'd50, 8'd50, 8'd50);
        bubble(2);
        beat(0, 0, 8'd30, 8'd60, 8'd60, 8'd60);
        bubble(1);
        beat(0, 0, 8'd20, 8'd70, 8'd70, 8'd70);
        bubble(3);
        beat(0, 1, 8'd255, 8'd9, 8'd8, 8'd7);
        n_checks++;
        if (res() !== {1'b1, 8'd9, 8'd8, 8'd7, 8'd255, 20'd3}) begin
            n_fail++; $display("FAIL bubble_result: got %h expected %h", res(), {1'b1, 8'd9, 8'd8, 8'd7, 8'd255, 20'd3});
        end
        beat(1, 0, 8'd40, 8'd4, 8'd4, 8'd4);
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.out_dark_max} !== {1'b0, 1'b1, 8'd255}) begin
            n_fail++; $display("FAIL b2b_overlap: got %h expected %h", {bus.out_valid, bus.busy, bus.out_dark_max}, {1'b0, 1'b1, 8'd255});
        end
        beat(0, 0, 8'd60, 8'd6, 8'd6, 8'd6);
        beat(0, 1, 8'd59, 8'd7, 8'd7, 8'd7);
        n_checks++;
        if (res() !== {1'b1, 8'd6, 8'd6, 8'd6, 8'd60, 20'd1}) begin
            n_fail++; $display("FAIL b2b_result: got %h expected %h", res(), {1'b1, 8'd6, 8'd6, 8'd6, 8'd60, 20'd1});
        end
        n_checks++;
        if (bus.frame_err !== 1'b0) begin
            n_fail++; $display("FAIL clean_frame_err: got %b expected 0", bus.frame_err);
        end
        bubble(1);
    endtask

    task automatic test_err_no_sof();
        beat(0, 1, 8'd99, 8'd99, 8'd99, 8'd99);
        n_checks++;
        if (bus.frame_err !== 1'b1) begin
            n_fail++; $display("FAIL nosof_err: got %b expected 1", bus.frame_err);
        end
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.out_dark_max} !== {1'b0, 1'b0, 8'd60}) begin
            n_fail++; $display("FAIL nosof_dropped: got %h expected %h", {bus.out_valid, bus.busy, bus.out_dark_max}, {1'b0, 1'b0, 8'd60});
        end
        bubble(1);
    endtask

    task automatic test_sof_mid();
        beat(1, 0, 8'd100, 8'd10, 8'd10, 8'd10);
        beat(0, 0, 8'd150, 8'd15, 8'd15, 8'd15);
        beat(1, 0, 8'd20, 8'd2, 8'd2, 8'd2);
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.frame_err} !== 3'b011) begin
            n_fail++; $display("FAIL midsof_state: got %b expected 011", {bus.out_valid, bus.busy, bus.frame_err});
        end
        beat(0, 0, 8'd30, 8'd3, 8'd3, 8'd3);
        beat(0, 1, 8'd25, 8'd4, 8'd4, 8'd4);
        n_checks++;
        if (res() !== {1'b1, 8'd3, 8'd3, 8'd3, 8'd30, 20'd1}) begin
            n_fail++; $display("FAIL midsof_result: got %h expected %h", res(), {1'b1, 8'd3, 8'd3, 8'd3, 8'd30, 20'd1});
        end
        bubble(1);
    endtask

    task automatic test_reset_mid();
        beat(1, 0, 8'd77, 8'd7, 8'd7, 8'd7);
        beat(0, 0, 8'd88, 8'd8, 8'd8, 8'd8);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({res(), bus.busy, bus.frame_err} !== 55'd0) begin
            n_fail++; $display("FAIL midreset_async: got %h expected 0", {res(), bus.busy, bus.frame_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        bubble(1);
        beat(1, 0, 8'd3, 8'd30, 8'd31, 8'd32);
        beat(0, 0, 8'd9, 8'd90, 8'd91, 8'd92);
        beat(0, 1, 8'd1, 8'd10, 8'd11, 8'd12);
        n_checks++;
        if (res() !== {1'b1, 8'd90, 8'd91, 8'd92, 8'd9, 20'd1}) begin
            n_fail++; $display("FAIL postreset_result: got %h expected %h", res(), {1'b1, 8'd90, 8'd91, 8'd92, 8'd9, 20'd1});
        end
        n_checks++;
        if (bus.frame_err !== 1'b0) begin
            n_fail++; $display("FAIL postreset_err: got %b expected 0", bus.frame_err);
        end
        bubble(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_single();
        test_back_to_back();
        test_err_no_sof();
        test_sof_mid();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/atmospheric_light_estimator.md
Name: atmospheric_light_estimator

Overview:
- Streaming stage downstream of the dark-channel/min-filter path; consumes one dark-channel value per pixel, together with the co-located hazy RGB pixel.
- Tracks the brightest dark-channel value across a frame and latches the matching RGB pixel as atmospheric light A.
- At end of frame it publishes A, the max dark value and the pixel index for the transmission-estimation stage.
- Per-pixel comparison uses strict greater-than on 8-bit unsigned values, the same as the team's comparator leaf.

Parameters:
- DATA_W, 8, bit width of dark value and each colour channel.
- IDX_W, 20, width of pixel index counter (supports frames up to 2^20 pixels).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat qualifier.
- in_sof  input  1  first pixel of frame; meaningful only when in_valid=1.
- in_eof  input  1  last pixel of frame; meaningful only when in_valid=1.
- in_dark  input  DATA_W  dark-channel value of the pixel.
- in_r, in_g, in_b  input  DATA_W each  hazy pixel colour.
- out_valid  output  1  one-cycle pulse when a frame result is published.
- out_a_r, out_a_g, out_a_b  output  DATA_W each  atmospheric light, held until the next publish.
- out_dark_max  output  DATA_W  max dark value of the published frame.
- out_idx  output  IDX_W  index of the winning pixel (0 = SOF pixel).
- busy  output  1  high while in ACCUM.
- frame_err  output  1  sticky; set on protocol error; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all outputs 0, internal max/argmax/counter 0.
- States: IDLE, ACCUM.
- IDLE: a beat with in_valid & in_sof loads max=in_dark, rgb=in pixel, idx=0, cnt=1.
  - If in_eof is also high, publish next edge and stay IDLE (single-pixel frame).
  - Otherwise go to ACCUM.
- IDLE, valid beat without in_sof: dropped; frame_err set.
- ACCUM, valid beat without sof: if in_dark > max (strict), load max/rgb/idx=cnt. cnt increments.
- ACCUM, valid beat with in_eof: compare-and-update as above, then publish and go to IDLE.
- ACCUM, in_sof seen: frame_err set; current accumulation discarded and restarted from this beat, exactly as the IDLE-sof path.
- Ties: the earliest pixel wins (strict >), so out_idx is the lowest index holding the max.
- Publish timing: out_valid=1 on the cycle after the eof beat is sampled.
  - out_* reflect the final compare including the eof pixel.
  - out_a_*, out_dark_max and out_idx update on the same edge and hold afterwards.
- in_valid=0 cycles: no state change, cnt frozen; bubbles are allowed anywhere in a frame.
- cnt saturates at 2^IDX_W-1. Beyond that, updates still occur but idx holds the saturated value, and frame_err is set.
- A new frame may start on the beat immediately after eof; the out_valid pulse and new accumulation overlap without interference.
- Reset mid-frame: accumulation abandoned, no publish, outputs return to 0.
- Registered outputs only; no combinational path from inputs to outputs.

Decomposition:
- Shared package (haze_pkg) holds:
  - DATA_W default
  - pixel RGB struct type
  - the IDLE/ACCUM state encoding
- Natural sub-module: argmax_reg, a compare-and-capture register holding value, payload and index.
  - Inputs: load (forced), cand_valid, cand value/payload/index.
  - Strict-greater update rule.
  - The FSM/counter wrapper stays in atmospheric_light_estimator.

Test Plan:
- 4-pixel frame, dark=10,200,50,199, RGB of pixel1=(220,210,205) -> out_valid one cycle after eof; A=(220,210,205), dark_max=200, idx=1.
- Tie: dark=90,90,90 with distinct RGB -> idx=0, and the A RGB is pixel0's.
- Single-pixel frame, sof&eof same beat, dark=7, RGB=(1,2,3) -> out_valid next cycle, A=(1,2,3), idx=0, busy never asserts.
- Frame with in_valid bubbles between beats, max on the eof pixel (dark=255) -> A equals the eof pixel and idx equals the count of valid beats minus 1. A second frame back-to-back starting right after eof publishes independently.
- Protocol errors, each -> frame_err=1:
  - a valid beat with no sof while IDLE -> dropped, no publish.
  - sof mid-frame -> restart; result covers only the pixels after the second sof.
- Reset asserted mid-frame -> outputs 0 immediately (async). A following full frame publishes correctly and frame_err is 0.
